// File: rtl/ibuf_pkg.sv
// Shared constants for the pad input buffer: parameter defaults, legal ranges
// and the width of the per-bit glitch-filter stability counter.
package ibuf_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 3;
  localparam int CNT_W_DEF       = 16;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILTER_LEN_MIN  = 1;
  localparam int FILTER_LEN_MAX  = 15;
  localparam int CNT_W_MIN       = 1;
  localparam int WIDTH_MIN       = 1;

  // The stability counter must be able to hold FILTER_LEN_MAX.
  localparam int STAB_W = 4;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/ibuf_bit.sv
// One buffered input bit: synchronizer chain, glitch filter, registered
// rise/fall detection and a wrapping transition counter.
module ibuf_bit
  import ibuf_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             sync_o,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [STAB_W-1:0]      stab_q;
  logic [STAB_W-1:0]      stab_n;
  logic                   cand_q;
  logic                   cand_n;
  logic                   filt_q;
  logic                   filt_n;
  logic                   filt_d;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILTER_LEN consecutive agreeing samples;
  // any disagreement restarts the run at 1 with the new candidate.
  always_comb begin
    stab_n = stab_q;
    cand_n = cand_q;
    filt_n = filt_q;
    if (sync_o == filt_q) begin
      stab_n = '0;
      cand_n = filt_q;
    end else begin
      if (sync_o != cand_q) begin
        stab_n = STAB_W'(1);
      end else begin
        stab_n = stab_q + STAB_W'(1);
      end
      cand_n = sync_o;
      if (stab_n == STAB_TARGET) begin
        filt_n = sync_o;
        stab_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_q <= '0;
      cand_q <= 1'b0;
      filt_q <= 1'b0;
      filt_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      stab_q <= stab_n;
      cand_q <= cand_n;
      filt_q <= filt_n;
      filt_d <= filt_q;
      rise_q <= filt_q & ~filt_d;
      fall_q <= ~filt_q & filt_d;
    end
  end

  // Clear wins over a coincident edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (rise_q | fall_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign filt_o   = filt_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_cnt = cnt_q;

endmodule

// File: rtl/ibuf_sync.sv
// Pad input buffer: zero-latency pass-through plus, per bit, a synchronized,
// glitch-filtered copy with edge pulses and a transition counter.
module ibuf_sync
  import ibuf_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   osc,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       I,
  output logic [WIDTH-1:0]       O,
  output logic [WIDTH-1:0]       sync_o,
  output logic [WIDTH-1:0]       filt_o,
  output logic [WIDTH-1:0]       rise_o,
  output logic [WIDTH-1:0]       fall_o,
  output logic [WIDTH*CNT_W-1:0] edge_cnt,
  input  logic                   cnt_clr
);

  if (WIDTH < WIDTH_MIN) begin : g_bad_width
    $error("ibuf_sync: WIDTH must be at least 1");
  end
  if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("ibuf_sync: SYNC_STAGES out of range 2..4");
  end
  if (!in_range(FILTER_LEN, FILTER_LEN_MIN, FILTER_LEN_MAX)) begin : g_bad_filter
    $error("ibuf_sync: FILTER_LEN out of range 1..15");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
    $error("ibuf_sync: CNT_W must be at least 1");
  end

  // Unclocked copy of the pad, standing in for a vendor IBUF.
  assign O = I;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    ibuf_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk     (osc),
      .rst     (rst),
      .din     (I[k]),
      .cnt_clr (cnt_clr),
      .sync_o  (sync_o[k]),
      .filt_o  (filt_o[k]),
      .rise_o  (rise_o[k]),
      .fall_o  (fall_o[k]),
      .edge_cnt(edge_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ibuf_sync.sv
// Scoreboard bench for ibuf_sync: a window-based reference model pushes the
// expected outputs each cycle; a monitor pops and compares on the falling edge.
module tb_ibuf_sync;

  localparam int W  = 3;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int CW = 4;

  logic            osc = 1'b0;
  logic            rst;
  logic            cnt_clr;
  logic [W-1:0]    I;
  logic [W-1:0]    O;
  logic [W-1:0]    sync_o;
  logic [W-1:0]    filt_o;
  logic [W-1:0]    rise_o;
  logic [W-1:0]    fall_o;
  logic [W*CW-1:0] edge_cnt;

  int checks = 0;
  int errors = 0;

  always #5 osc = ~osc;

  ibuf_sync #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .FILTER_LEN (FL),
    .CNT_W      (CW)
  ) dut (
    .osc     (osc),
    .rst     (rst),
    .I       (I),
    .O       (O),
    .sync_o  (sync_o),
    .filt_o  (filt_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .edge_cnt(edge_cnt),
    .cnt_clr (cnt_clr)
  );

  typedef struct packed {
    logic [W-1:0]    sync;
    logic [W-1:0]    filt;
    logic [W-1:0]    rise;
    logic [W-1:0]    fall;
    logic [W*CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: I delayed by SS edges, the last FL synchronized
  // samples, the filtered level and its edge pulses, and integer counters.
  logic [W-1:0] m_pipe[SS];
  logic [W-1:0] m_hist[FL];
  logic [W-1:0] m_filt;
  logic [W-1:0] m_filt_prev;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  int           m_cnt[W];

  always @(posedge osc) begin : model
    exp_t         e;
    logic [W-1:0] new_rise;
    logic [W-1:0] new_fall;
    logic         same;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      for (int k = 0; k < FL; k++) m_hist[k] = '0;
      m_filt      = '0;
      m_filt_prev = '0;
      m_rise      = '0;
      m_fall      = '0;
      for (int b = 0; b < W; b++) m_cnt[b] = 0;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (cnt_clr) m_cnt[b] = 0;
        else if (m_rise[b] || m_fall[b]) m_cnt[b] = (m_cnt[b] + 1) % (1 << CW);
      end
      new_rise    = m_filt & ~m_filt_prev;
      new_fall    = ~m_filt & m_filt_prev;
      m_filt_prev = m_filt;
      for (int k = FL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_pipe[SS-1];
      for (int b = 0; b < W; b++) begin
        same = 1'b1;
        for (int k = 1; k < FL; k++) if (m_hist[k][b] != m_hist[0][b]) same = 1'b0;
        if (same && (m_hist[0][b] != m_filt[b])) m_filt[b] = m_hist[0][b];
      end
      m_rise = new_rise;
      m_fall = new_fall;
      for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = I;
    end
    e.sync = m_pipe[SS-1];
    e.filt = m_filt;
    e.rise = m_rise;
    e.fall = m_fall;
    for (int b = 0; b < W; b++) e.cnt[b*CW +: CW] = CW'(m_cnt[b]);
    exp_q.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge osc) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sync_o", 64'(sync_o), 64'(e.sync));
      checkOutput("filt_o", 64'(filt_o), 64'(e.filt));
      checkOutput("rise_o", 64'(rise_o), 64'(e.rise));
      checkOutput("fall_o", 64'(fall_o), 64'(e.fall));
      checkOutput("edge_cnt", 64'(edge_cnt), 64'(e.cnt));
    end
    checkOutput("O", 64'(O), 64'(I));
  end

  // Inputs change 2 time units after a rising edge and are held n cycles.
  task automatic applyStimulus(input logic [W-1:0] iv, input logic r, input logic c, input int n);
    I       = iv;
    rst     = r;
    cnt_clr = c;
    repeat (n) begin
      @(posedge osc);
      #2;
    end
  endtask

  task automatic measureLatency(input string name, input logic [W-1:0] target);
    int lat;
    lat = 0;
    while (filt_o !== target && lat < 30) begin
      @(posedge osc);
      #2;
      lat++;
    end
    checkOutput(name, 64'(lat), 64'(SS + FL));
  endtask

  logic [W-1:0] cur;

  initial begin
    int  waited;
    logic r;
    logic c;

    applyStimulus('1, 1'b1, 1'b0, 5);
    applyStimulus('0, 1'b0, 1'b0, 5);

    // Step on bit 0 from a settled all-zero state.
    I = 3'b001;
    measureLatency("step_latency", 3'b001);
    applyStimulus(3'b001, 1'b0, 1'b0, 6);

    // Two-cycle glitch on bit 1.
    applyStimulus(3'b011, 1'b0, 1'b0, 2);
    applyStimulus(3'b001, 1'b0, 1'b0, 10);

    // Eight transitions on bit 0, then a clear landing on a fall pulse.
    cur = 3'b001;
    for (int k = 0; k < 8; k++) begin
      cur[0] = ~cur[0];
      applyStimulus(cur, 1'b0, 1'b0, 10);
    end
    cur[0] = 1'b0;
    applyStimulus(cur, 1'b0, 1'b0, 1);
    waited = 0;
    while (m_fall[0] !== 1'b1 && waited < 20) begin
      applyStimulus(cur, 1'b0, 1'b0, 1);
      waited++;
    end
    checkOutput("fall_wait_bound", 64'(waited < 20), 64'(1));
    applyStimulus(cur, 1'b0, 1'b1, 1);
    applyStimulus(cur, 1'b0, 1'b0, 5);

    // Seventeen transitions on bit 2 wrap the 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      cur[2] = ~cur[2];
      applyStimulus(cur, 1'b0, 1'b0, 7);
    end
    applyStimulus(cur, 1'b0, 1'b0, 6);

    // Multi-bit step, reset mid-filter, then full latency again.
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus('0, 1'b0, 1'b0, 10);
    I = 3'b101;
    measureLatency("multi_latency", 3'b101);
    applyStimulus('0, 1'b0, 1'b0, 10);
    applyStimulus(3'b101, 1'b0, 1'b0, 3);
    applyStimulus(3'b101, 1'b1, 1'b0, 1);
    rst = 1'b0;
    measureLatency("post_reset_latency", 3'b101);
    applyStimulus(3'b101, 1'b0, 1'b0, 5);

    // Randomized segments.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 14) == 0);
      applyStimulus(W'($urandom), r, c, $urandom_range(1, 8));
    end
    applyStimulus(I, 1'b0, 1'b0, 3);

    checkOutput("queue_drained", 64'(exp_q.size() <= 1), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
